// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Purely declarative, no latency or flow control of its own.
// Widths here are defaults only; the top exposes them as parameters.
package alu_arb_pkg;

    localparam int ALU_DATA_WIDTH = 32;
    localparam int ALU_SEL_WIDTH  = 3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: the requester not served last wins a tie.
// Zero latency, purely combinational.
// No backpressure; the caller decides when the grant is consumed.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic gnt_id,
    output logic gnt_vld
);

    assign gnt_vld = valid0 | valid1;
    assign gnt_id  = (valid0 & valid1) ? ~last : valid1;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, one op in flight.
// Accept-to-response latency 2 cycles; peak throughput 1 op per 3 cycles.
// Requests wait (ready low) outside IDLE; response holds until its ready.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int SEL_WIDTH  = ALU_SEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    input  logic [SEL_WIDTH-1:0]  req0_sel,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    input  logic [SEL_WIDTH-1:0]  req1_sel,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic                  resp_zero,
    output logic [DATA_WIDTH-1:0] alu_operand1,
    output logic [DATA_WIDTH-1:0] alu_operand2,
    output logic [SEL_WIDTH-1:0]  alu_opsel,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  busy
);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic                  gnt_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;

    logic gnt_id;
    logic gnt_vld;
    logic idle;
    logic resp_rdy;

    rr_arb2 u_rr_arb2 (
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .last    (last_q),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    assign idle       = (state_q == ST_IDLE);
    assign req0_ready = idle & gnt_vld & ~gnt_id;
    assign req1_ready = idle & gnt_vld &  gnt_id;

    assign resp0_valid = (state_q == ST_RESP) & ~gnt_q;
    assign resp1_valid = (state_q == ST_RESP) &  gnt_q;
    assign resp_rdy    = gnt_q ? resp1_ready : resp0_ready;

    assign resp_result  = result_q;
    assign resp_zero    = zero_q;
    assign alu_operand1 = op1_q;
    assign alu_operand2 = op2_q;
    assign alu_opsel    = sel_q;
    assign busy         = ~idle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            sel_q    <= '0;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A grant in IDLE is exactly the valid&&ready handshake.
                    if (gnt_vld) begin
                        op1_q   <= gnt_id ? req1_op1 : req0_op1;
                        op2_q   <= gnt_id ? req1_op2 : req0_op2;
                        sel_q   <= gnt_id ? req1_sel : req0_sel;
                        gnt_q   <= gnt_id;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_rdy) begin
                        last_q  <= gnt_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with an external behavioural ALU and a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [2:0]  req0_sel = '0, req1_sel = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic [31:0] alu_operand1, alu_operand2, alu_result;
    logic [2:0]  alu_opsel;
    logic        alu_zero;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op1     (req0_op1),
        .req0_op2     (req0_op2),
        .req0_sel     (req0_sel),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op1     (req1_op1),
        .req1_op2     (req1_op2),
        .req1_sel     (req1_sel),
        .resp0_valid  (resp0_valid),
        .resp0_ready  (resp0_ready),
        .resp1_valid  (resp1_valid),
        .resp1_ready  (resp1_ready),
        .resp_result  (resp_result),
        .resp_zero    (resp_zero),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_opsel    (alu_opsel),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .busy         (busy)
    );

    function automatic logic [31:0] alu_ref(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            3'b000:  return a & b;
            3'b001:  return a - b;
            3'b010:  return a + b;
            3'b011:  return a | b;
            3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // The ALU that sits beside the arbiter at the top level.
    assign alu_result = alu_ref(alu_opsel, alu_operand1, alu_operand2);
    assign alu_zero   = (alu_result == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: one op in flight, owner, captured flag, last served.
    logic        m_inflight = 1'b0;
    logic        m_captured = 1'b0;
    logic        m_owner    = 1'b0;
    logic        m_last     = 1'b1;
    logic [31:0] m_op1 = '0, m_op2 = '0, m_res = '0;
    logic [2:0]  m_sel = '0;
    logic        m_zero = 1'b0;

    function automatic int pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_inflight <= 1'b0;
            m_captured <= 1'b0;
            m_owner    <= 1'b0;
            m_last     <= 1'b1;
            m_op1      <= '0;
            m_op2      <= '0;
            m_sel      <= '0;
            m_res      <= '0;
            m_zero     <= 1'b0;
        end else if (!m_inflight) begin
            if (pick(req0_valid, req1_valid, m_last) == 0) begin
                m_inflight <= 1'b1;
                m_owner    <= 1'b0;
                m_op1      <= req0_op1;
                m_op2      <= req0_op2;
                m_sel      <= req0_sel;
            end else if (pick(req0_valid, req1_valid, m_last) == 1) begin
                m_inflight <= 1'b1;
                m_owner    <= 1'b1;
                m_op1      <= req1_op1;
                m_op2      <= req1_op2;
                m_sel      <= req1_sel;
            end
        end else if (!m_captured) begin
            m_res      <= alu_ref(m_sel, m_op1, m_op2);
            m_zero     <= (alu_ref(m_sel, m_op1, m_op2) == 32'd0);
            m_captured <= 1'b1;
        end else if (m_owner ? resp1_ready : resp0_ready) begin
            m_inflight <= 1'b0;
            m_captured <= 1'b0;
            m_last     <= m_owner;
        end
    end

    always @(negedge clk) begin
        int g;
        g = m_inflight ? -1 : pick(req0_valid, req1_valid, m_last);
        chk("m_req0_ready",  {31'd0, req0_ready},  {31'd0, g == 0});
        chk("m_req1_ready",  {31'd0, req1_ready},  {31'd0, g == 1});
        chk("m_resp0_valid", {31'd0, resp0_valid}, {31'd0, m_inflight && m_captured && !m_owner});
        chk("m_resp1_valid", {31'd0, resp1_valid}, {31'd0, m_inflight && m_captured && m_owner});
        chk("m_busy",        {31'd0, busy},        {31'd0, m_inflight});
        chk("m_alu_op1",     alu_operand1,         m_op1);
        chk("m_alu_op2",     alu_operand2,         m_op2);
        chk("m_alu_opsel",   {29'd0, alu_opsel},   {29'd0, m_sel});
        chk("m_resp_result", resp_result,          m_res);
        chk("m_resp_zero",   {31'd0, resp_zero},   {31'd0, m_zero});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
        if (n == 0) begin
            req0_valid = v; req0_op1 = a; req0_op2 = b; req0_sel = s;
        end else begin
            req1_valid = v; req1_op1 = a; req1_op2 = b; req1_sel = s;
        end
    endtask

    initial begin
        logic hs0, hs1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     {31'd0, busy},        32'd0);
        chk("rst_resp0",    {31'd0, resp0_valid}, 32'd0);
        chk("rst_result",   resp_result,          32'd0);
        chk("rst_alu_op1",  alu_operand1,         32'd0);
        tick();
        rst = 1'b1;

        // req0 ADD 5,7 alone
        set_req(0, 1'b1, 32'd5, 32'd7, 3'b010);
        resp0_ready = 1'b1;
        @(negedge clk);
        chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_c1_resp0", {31'd0, resp0_valid}, 32'd0);
        chk("t1_c1_busy",  {31'd0, busy},        32'd1);
        tick();
        @(negedge clk);
        chk("t1_c2_resp0",  {31'd0, resp0_valid}, 32'd1);
        chk("t1_c2_resp1",  {31'd0, resp1_valid}, 32'd0);
        chk("t1_c2_result", resp_result,          32'd12);
        chk("t1_c2_zero",   {31'd0, resp_zero},   32'd0);
        tick();

        // Both valid from reset: alternation over 10 ops
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_req(0, 1'b1, 32'd9, 32'd9, 3'b001);
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b100);
        resp1_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t2_ready0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_ready1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            tick();
            @(negedge clk);
            chk("t2_resp_vld", {31'd0, (k % 2 == 0) ? resp0_valid : resp1_valid}, 32'd1);
            chk("t2_result",   resp_result,        (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("t2_zero",     {31'd0, resp_zero}, (k % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // req1 OR with response backpressure, req0 waiting
        req0_valid  = 1'b0;
        resp1_ready = 1'b0;
        set_req(1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b011);
        @(negedge clk);
        chk("t3_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        set_req(0, 1'b1, 32'd1, 32'd2, 3'b010);
        @(negedge clk);
        chk("t3_c1_ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hold_resp1",  {31'd0, resp1_valid}, 32'd1);
            chk("t3_hold_result", resp_result,          32'h0000_00FF);
            chk("t3_hold_ready0", {31'd0, req0_ready},  32'd0);
            tick();
        end
        resp1_ready = 1'b1;
        @(negedge clk);
        chk("t3_hs_ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("t3_after_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t3_resp0_result", resp_result, 32'd3);
        tick();

        // Sel 111 passes through; ALU default result
        set_req(1, 1'b1, 32'h1234, 32'h5678, 3'b111);
        @(negedge clk);
        chk("t4_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t4_resp1", {31'd0, resp1_valid}, 32'd1);
        chk("t4_result", resp_result,         32'd0);
        chk("t4_zero",  {31'd0, resp_zero},   32'd1);
        tick();

        // Reset during EXEC
        set_req(1, 1'b1, 32'hFF, 32'hFF, 3'b000);
        tick();
        req1_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t5_busy",    {31'd0, busy},        32'd0);
        chk("t5_alu_op1", alu_operand1,         32'd0);
        chk("t5_resp1",   {31'd0, resp1_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_no_resp1", {31'd0, resp1_valid}, 32'd0);
            tick();
        end
        set_req(0, 1'b1, 32'd2, 32'd2, 3'b010);
        set_req(1, 1'b1, 32'd3, 32'd3, 3'b010);
        @(negedge clk);
        chk("t5_ready0", {31'd0, req0_ready}, 32'd1);
        chk("t5_ready1", {31'd0, req1_ready}, 32'd0);

        // Randomized traffic with occasional resets
        hs0 = 1'b0;
        hs1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs0 = req0_valid && req0_ready && rst;
            hs1 = req1_valid && req1_ready && rst;
            @(posedge clk);
            #1;
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst = 1'b0;
            if (hs0 || !req0_valid)
                set_req(0, $urandom_range(0, 2) != 0, $urandom,
                        ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 3'($urandom_range(0, 7)));
            if (hs1 || !req1_valid)
                set_req(1, $urandom_range(0, 2) != 0, $urandom_range(0, 15),
                        $urandom_range(0, 15), 3'($urandom_range(0, 7)));
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
        end

        rst = 1'b1;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("drain_busy", {31'd0, busy}, 32'd0);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
